// File: rtl/dmem_responder_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_responder_pkg : FSM state and RISC-V funct3 size/sign encodings   |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
package dmem_responder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } dmem_state_e;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

endpackage
`default_nettype wire

// File: rtl/dmem_lane_align.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_lane_align : store lane merge, load extract/extend, error detect  |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module dmem_lane_align
  import dmem_responder_pkg::*;
(
  input  logic        we,
  input  logic [1:0]  addr_lo,
  input  logic [2:0]  funct3,
  input  logic [31:0] wdata,
  input  logic [31:0] rword,
  output logic        err,
  output logic        wr_en,
  output logic [31:0] wr_word,
  output logic [31:0] rdata
);

  logic        illegal;
  logic        misaligned;
  logic [3:0]  be;
  logic [31:0] wrep;
  logic [7:0]  rbyte;
  logic [15:0] rhalf;

  always_comb begin
    illegal    = 1'b0;
    misaligned = 1'b0;
    if (we)
      illegal = !(funct3 inside {F3_SB, F3_SH, F3_SW});
    else
      illegal = !(funct3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU});
    // funct3[1:0] carries the access size for both loads and stores
    case (funct3[1:0])
      2'b01:   misaligned = addr_lo[0];
      2'b10:   misaligned = |addr_lo;
      default: misaligned = 1'b0;
    endcase
    err   = illegal | misaligned;
    wr_en = we & ~err;
  end

  always_comb begin
    be   = 4'b1111;
    wrep = wdata;
    case (funct3[1:0])
      2'b00: begin
        be   = 4'b0001 << addr_lo;
        wrep = {4{wdata[7:0]}};
      end
      2'b01: begin
        be   = addr_lo[1] ? 4'b1100 : 4'b0011;
        wrep = {2{wdata[15:0]}};
      end
      default: begin
        be   = 4'b1111;
        wrep = wdata;
      end
    endcase
    wr_word = rword;
    for (int i = 0; i < 4; i++)
      if (be[i]) wr_word[8*i +: 8] = wrep[8*i +: 8];
  end

  always_comb begin
    rbyte = rword[{addr_lo, 3'b000} +: 8];
    rhalf = addr_lo[1] ? rword[31:16] : rword[15:0];
    case (funct3)
      F3_LB:   rdata = {{24{rbyte[7]}}, rbyte};
      F3_LH:   rdata = {{16{rhalf[15]}}, rhalf};
      F3_LW:   rdata = rword;
      F3_LBU:  rdata = {24'b0, rbyte};
      F3_LHU:  rdata = {16'b0, rhalf};
      default: rdata = '0;
    endcase
    if (we || err) rdata = '0;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | dmem_responder : wait-stated data memory with valid/ready handshakes   |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_W      = 9,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [2:0]        req_funct3,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              busy
);

  localparam int         DEPTH    = 1 << (ADDR_W - 2);
  localparam logic       NO_WAIT  = (WAIT_CYCLES == 0);
  localparam logic [3:0] CNT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  dmem_state_e       state;
  logic [3:0]        cnt;
  logic              lat_we;
  logic [ADDR_W-1:0] lat_addr;
  logic [DATA_W-1:0] lat_wdata;
  logic [2:0]        lat_funct3;

  logic [DATA_W-1:0] mem [DEPTH];

  logic              acc_we;
  logic [ADDR_W-1:0] acc_addr;
  logic [DATA_W-1:0] acc_wdata;
  logic [2:0]        acc_funct3;
  logic [DATA_W-1:0] rword;
  logic              al_err;
  logic              al_wr_en;
  logic [DATA_W-1:0] al_wr_word;
  logic [DATA_W-1:0] al_rdata;
  logic              enter_resp;

  // With no wait states the access happens on the accept edge, so the
  // live request feeds the lane logic while idle.
  always_comb begin
    if (state == ST_IDLE) begin
      acc_we     = req_we;
      acc_addr   = req_addr;
      acc_wdata  = req_wdata;
      acc_funct3 = req_funct3;
    end else begin
      acc_we     = lat_we;
      acc_addr   = lat_addr;
      acc_wdata  = lat_wdata;
      acc_funct3 = lat_funct3;
    end
    rword      = mem[acc_addr[ADDR_W-1:2]];
    enter_resp = ((state == ST_IDLE) && req_valid && NO_WAIT) ||
                 ((state == ST_WAIT) && (cnt == 4'd0));
  end

  dmem_lane_align u_align (
    .we      (acc_we),
    .addr_lo (acc_addr[1:0]),
    .funct3  (acc_funct3),
    .wdata   (acc_wdata),
    .rword   (rword),
    .err     (al_err),
    .wr_en   (al_wr_en),
    .wr_word (al_wr_word),
    .rdata   (al_rdata)
  );

  always_ff @(posedge clk) begin
    if (!reset && enter_resp && al_wr_en)
      mem[acc_addr[ADDR_W-1:2]] <= al_wr_word;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= ST_IDLE;
      cnt       <= 4'd0;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      busy      <= 1'b0;
      req_ready <= 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (req_valid) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_wdata  <= req_wdata;
            lat_funct3 <= req_funct3;
            busy       <= 1'b1;
            req_ready  <= 1'b0;
            if (NO_WAIT) begin
              state     <= ST_RESP;
              rsp_valid <= 1'b1;
              rsp_rdata <= al_rdata;
              rsp_err   <= al_err;
            end else begin
              state <= ST_WAIT;
              cnt   <= CNT_LOAD;
            end
          end
        end
        ST_WAIT: begin
          if (cnt == 4'd0) begin
            state     <= ST_RESP;
            rsp_valid <= 1'b1;
            rsp_rdata <= al_rdata;
            rsp_err   <= al_err;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            state     <= ST_IDLE;
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
            busy      <= 1'b0;
            req_ready <= 1'b1;
          end
        end
        default: begin
          state     <= ST_IDLE;
          rsp_valid <= 1'b0;
          busy      <= 1'b0;
          req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_dmem_responder : randomized traffic against a byte-array model      |
// | rev 1.0                                                                |
// +-----------------------------------------------------------------------+
module tb_dmem_responder;

  localparam int WAITC = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0, rsp_ready = 1'b0;
  logic [8:0]  req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic [2:0]  req_funct3 = '0;
  logic        req_ready, rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        req_valid_z = 1'b0, req_we_z = 1'b0, rsp_ready_z = 1'b0;
  logic [8:0]  req_addr_z = '0;
  logic [31:0] req_wdata_z = '0;
  logic [2:0]  req_funct3_z = '0;
  logic        req_ready_z, rsp_valid_z, rsp_err_z, busy_z;
  logic [31:0] rsp_rdata_z;

  always #5 clk = ~clk;

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(WAITC)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .req_funct3(req_funct3), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  dmem_responder #(.ADDR_W(9), .DATA_W(32), .WAIT_CYCLES(0)) dut_z (
    .clk(clk), .reset(reset), .req_valid(req_valid_z), .req_ready(req_ready_z),
    .req_we(req_we_z), .req_addr(req_addr_z), .req_wdata(req_wdata_z),
    .req_funct3(req_funct3_z), .rsp_valid(rsp_valid_z), .rsp_ready(rsp_ready_z),
    .rsp_rdata(rsp_rdata_z), .rsp_err(rsp_err_z), .busy(busy_z)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference memory kept as bytes; accesses are plain byte arithmetic.
  logic [7:0] mb [512];

  task automatic model_access(input logic we, input logic [8:0] a, input logic [31:0] wd,
                              input logic [2:0] f3, output logic [31:0] rd, output logic er);
    int  sz;
    bit  sgn, legal;
    logic [31:0] v;
    sz = 0; sgn = 0; legal = 1; v = '0;
    case (f3)
      3'd0: begin sz = 1; sgn = 1; end
      3'd1: begin sz = 2; sgn = 1; end
      3'd2: sz = 4;
      3'd4: begin sz = 1; legal = !we; end
      3'd5: begin sz = 2; legal = !we; end
      default: legal = 0;
    endcase
    er = !legal || ((int'(a) % sz) != 0);
    rd = '0;
    if (!er) begin
      if (we) begin
        for (int i = 0; i < sz; i++) mb[int'(a) + i] = wd[8*i +: 8];
      end else begin
        for (int i = 0; i < sz; i++) v[8*i +: 8] = mb[int'(a) + i];
        if (sgn && sz == 1 && v[7])  v = v | 32'hFFFF_FF00;
        if (sgn && sz == 2 && v[15]) v = v | 32'hFFFF_0000;
        rd = v;
      end
    end
  endtask

  logic        cmp_en = 1'b0;
  logic        exp_idle = 1'b1, exp_valid = 1'b0, exp_err = 1'b0;
  logic [31:0] exp_rdata = '0;

  always @(negedge clk) begin
    if (cmp_en) begin
      chk("req_ready", {31'b0, req_ready}, {31'b0, exp_idle});
      chk("busy", {31'b0, busy}, {31'b0, !exp_idle});
      chk("rsp_valid", {31'b0, rsp_valid}, {31'b0, exp_valid});
      if (exp_valid) begin
        chk("rsp_rdata", rsp_rdata, exp_rdata);
        chk("rsp_err", {31'b0, rsp_err}, {31'b0, exp_err});
      end
    end
  end

  task automatic drive_junk(input bit junk);
    req_valid  = junk;
    req_we     = 1'b1;
    req_addr   = 9'($urandom);
    req_wdata  = $urandom;
    req_funct3 = 3'($urandom);
    rsp_ready  = 1'($urandom);
  endtask

  task automatic txn(input logic we, input logic [8:0] a, input logic [31:0] wd,
                     input logic [2:0] f3, input int hold, input bit junk,
                     output logic [31:0] got, output logic got_err);
    logic [31:0] erd;
    logic        eerr;
    req_valid = 1'b1; req_we = we; req_addr = a; req_wdata = wd; req_funct3 = f3;
    rsp_ready = 1'b0;
    @(posedge clk);
    model_access(we, a, wd, f3, erd, eerr);
    #1;
    exp_idle = 1'b0;
    drive_junk(junk);
    for (int k = 0; k < WAITC; k++) begin
      @(posedge clk); #1;
      drive_junk(junk);
    end
    exp_valid = 1'b1; exp_rdata = erd; exp_err = eerr;
    for (int k = 0; k < hold; k++) begin
      rsp_ready = 1'b0;
      @(posedge clk); #1;
      drive_junk(junk);
    end
    rsp_ready = 1'b1;
    got = rsp_rdata; got_err = rsp_err;
    @(posedge clk); #1;
    rsp_ready = 1'b0; req_valid = 1'b0;
    exp_valid = 1'b0; exp_idle = 1'b1;
  endtask

  logic [31:0] g;
  logic        ge;

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_req_ready", {31'b0, req_ready}, 32'd1);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    chk("reset_rsp_rdata", rsp_rdata, 32'd0);
    chk("reset_rsp_err", {31'b0, rsp_err}, 32'd0);
    reset = 1'b0;
    cmp_en = 1'b1;

    for (int i = 0; i < 128; i++)
      txn(1'b1, 9'(i * 4), 32'hC0DE_0000 | 32'(i), 3'd2, 0, 1'b0, g, ge);

    txn(1'b1, 9'h010, 32'hDEADBEEF, 3'd2, 0, 1'b0, g, ge);
    chk("sw_0x010_rdata", g, 32'd0);
    txn(1'b0, 9'h010, 32'd0, 3'd2, 0, 1'b0, g, ge);
    chk("lw_0x010", g, 32'hDEADBEEF);
    chk("lw_0x010_err", {31'b0, ge}, 32'd0);
    txn(1'b0, 9'h013, 32'd0, 3'd0, 0, 1'b0, g, ge);
    chk("lb_0x013", g, 32'hFFFFFFDE);
    txn(1'b0, 9'h013, 32'd0, 3'd4, 0, 1'b0, g, ge);
    chk("lbu_0x013", g, 32'h000000DE);
    txn(1'b0, 9'h012, 32'd0, 3'd1, 0, 1'b0, g, ge);
    chk("lh_0x012", g, 32'hFFFFDEAD);
    txn(1'b0, 9'h010, 32'd0, 3'd5, 0, 1'b0, g, ge);
    chk("lhu_0x010", g, 32'h0000BEEF);
    txn(1'b1, 9'h011, 32'h00000055, 3'd0, 0, 1'b0, g, ge);
    txn(1'b0, 9'h010, 32'd0, 3'd2, 0, 1'b0, g, ge);
    chk("sb_then_lw", g, 32'hDEAD55EF);
    txn(1'b0, 9'h012, 32'd0, 3'd2, 0, 1'b0, g, ge);
    chk("lw_mis_err", {31'b0, ge}, 32'd1);
    chk("lw_mis_rdata", g, 32'd0);
    txn(1'b1, 9'h011, 32'hFFFF_FFFF, 3'd1, 0, 1'b0, g, ge);
    chk("sh_mis_err", {31'b0, ge}, 32'd1);
    txn(1'b0, 9'h010, 32'd0, 3'd2, 5, 1'b1, g, ge);
    chk("lw_after_err_hold", g, 32'hDEAD55EF);
    txn(1'b0, 9'h014, 32'd0, 3'd3, 1, 1'b0, g, ge);
    chk("illegal_f3_err", {31'b0, ge}, 32'd1);

    // Reset one cycle after accepting a store: no response, no write.
    req_valid = 1'b1; req_we = 1'b1; req_addr = 9'h020; req_wdata = 32'h12345678;
    req_funct3 = 3'd2;
    @(posedge clk); #1;
    req_valid = 1'b0; exp_idle = 1'b0; reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; exp_idle = 1'b1;
    chk("midreset_rdata", rsp_rdata, 32'd0);
    chk("midreset_err", {31'b0, rsp_err}, 32'd0);
    txn(1'b0, 9'h020, 32'd0, 3'd2, 0, 1'b0, g, ge);
    chk("lw_0x020_after_reset", g, 32'hC0DE0008);

    for (int n = 0; n < 200; n++) begin
      logic [8:0] a;
      logic [2:0] f3;
      logic [2:0] legal_f3 [5];
      legal_f3 = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      a  = 9'($urandom);
      if ($urandom_range(0, 1) == 1) a[1:0] = 2'b00;
      f3 = ($urandom_range(0, 3) == 0) ? 3'($urandom) : legal_f3[$urandom_range(0, 4)];
      txn(1'($urandom), a, $urandom, f3, $urandom_range(0, 3), 1'($urandom), g, ge);
    end

    // Zero-wait-state build: response one cycle after the accept.
    cmp_en = 1'b0;
    req_valid_z = 1'b1; req_we_z = 1'b1; req_addr_z = 9'h004;
    req_wdata_z = 32'hA5A5_1234; req_funct3_z = 3'd2;
    @(posedge clk); #1;
    req_valid_z = 1'b0;
    chk("z_sw_valid", {31'b0, rsp_valid_z}, 32'd1);
    chk("z_sw_busy", {31'b0, busy_z}, 32'd1);
    rsp_ready_z = 1'b1;
    @(posedge clk); #1;
    rsp_ready_z = 1'b0;
    chk("z_idle_after_hs", {31'b0, req_ready_z}, 32'd1);
    req_valid_z = 1'b1; req_we_z = 1'b0; req_funct3_z = 3'd1; req_addr_z = 9'h006;
    chk("z_lh_not_yet_valid", {31'b0, rsp_valid_z}, 32'd0);
    @(posedge clk); #1;
    req_valid_z = 1'b0;
    chk("z_lh_valid", {31'b0, rsp_valid_z}, 32'd1);
    chk("z_lh_rdata", rsp_rdata_z, 32'hFFFF_A5A5);
    rsp_ready_z = 1'b1;
    @(posedge clk); #1;
    rsp_ready_z = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
